// File: rtl/mapper_konami_multi_pkg.sv
// Shared mapper definitions: mapper type encoding, Konami bank reset image
// and the SCC register window constants.
package mapper_pkg;

    typedef enum logic [2:0] {
        MAPPER_NONE       = 3'd0,
        MAPPER_ASCII8     = 3'd1,
        MAPPER_ASCII16    = 3'd2,
        MAPPER_KONAMI     = 3'd3,
        MAPPER_KONAMI_SCC = 3'd4
    } mapper_typ_t;

    // Element [p] is the power-up bank of page p (4000h, 6000h, 8000h, A000h).
    localparam logic [3:0][7:0] KONAMI_BANK_RESET = {8'd3, 8'd2, 8'd1, 8'd0};

    localparam logic [5:0]  SCC_ENABLE_VAL = 6'h3F;
    localparam logic [15:0] SCC_WIN_BASE   = 16'h9800;
    localparam logic [15:0] SCC_WIN_END    = 16'h9FFF;

endpackage

// File: rtl/mapper_konami_multi_if.sv
// CPU-side request and ROM/SCC select bundle between bus decode and the mapper.
interface mapper_konami_multi_if
    import mapper_pkg::*;
#(
    parameter int ID_W = 1
) ();

    mapper_typ_t      typ;
    logic [ID_W-1:0]  id;
    logic             mreq;
    logic             wr;
    logic             rd;
    logic [15:0]      addr;
    logic [7:0]       data;
    logic [26:0]      rom_size;
    logic [26:0]      out_addr;
    logic             ram_cs;
    logic             scc_cs;

    modport master (
        output typ, id, mreq, wr, rd, addr, data, rom_size,
        input  out_addr, ram_cs, scc_cs
    );

    modport slave (
        input  typ, id, mreq, wr, rd, addr, data, rom_size,
        output out_addr, ram_cs, scc_cs
    );

endinterface

// File: rtl/mapper_konami_multi_bank_file.sv
// Per-slot bank registers: one write port, a selectable read port and a fixed
// read of page 2, which also carries the SCC enable pattern.
module konami_bank_file
    import mapper_pkg::*;
#(
    parameter int SLOTS  = 2,
    parameter int BANK_W = 8,
    parameter int ID_W   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ID_W-1:0]   wr_slot_i,
    input  logic [1:0]        wr_page_i,
    input  logic [BANK_W-1:0] wr_val_i,
    input  logic              we_i,
    input  logic [ID_W-1:0]   rd_slot_i,
    input  logic [1:0]        rd_page_i,
    output logic [BANK_W-1:0] rd_val_o,
    output logic [BANK_W-1:0] rd_p2_o
);

    logic [BANK_W-1:0] bank_q [SLOTS][4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SLOTS; s++) begin
                for (int p = 0; p < 4; p++) begin
                    bank_q[s][p] <= BANK_W'(KONAMI_BANK_RESET[p]);
                end
            end
        end else if (we_i) begin
            bank_q[wr_slot_i][wr_page_i] <= wr_val_i;
        end
    end

    assign rd_val_o = bank_q[rd_slot_i][rd_page_i];
    assign rd_p2_o  = bank_q[rd_slot_i][2];

endmodule

// File: rtl/mapper_konami_multi.sv
// Konami / Konami-SCC ROM mapper for SLOTS cartridge instances: bank-register
// commit on the rising edge of wr, page translation and registered selects.
module mapper_konami_multi
    import mapper_pkg::*;
#(
    parameter int SLOTS  = 2,
    parameter int BANK_W = 8,
    parameter int ID_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic clk,
    input  logic reset_n,
    mapper_konami_multi_if.slave bus
);

    function automatic logic scc_enabled(input logic [BANK_W-1:0] b);
        return (14'(b) & 14'h003F) == 14'(SCC_ENABLE_VAL);
    endfunction

    logic              wr_q;
    logic [26:0]       out_addr_q, out_addr_d;
    logic              ram_cs_q, ram_cs_d;
    logic              scc_cs_q, scc_cs_d;

    logic              is_konami, is_scc, id_ok, cs, commit;
    logic [ID_W-1:0]   slot;
    logic [2:0]        seg;
    logic [1:0]        page;
    logic              in_rng, kon_wsel, scc_wsel, we;
    logic [BANK_W-1:0] rd_val, rd_p2, bank_sel;
    logic [26:0]       ram_addr;
    logic              scc_en, win, mapped;

    assign is_konami = (bus.typ == MAPPER_KONAMI);
    assign is_scc    = (bus.typ == MAPPER_KONAMI_SCC);
    assign id_ok     = 32'(bus.id) < 32'(SLOTS);
    assign cs        = bus.mreq & (is_konami | is_scc) & id_ok;
    // wr_q follows raw wr regardless of slot, so switching id mid-strobe never re-arms.
    assign commit    = cs & bus.wr & ~wr_q;
    assign slot      = id_ok ? bus.id : '0;

    assign seg    = bus.addr[15:13];
    assign in_rng = seg inside {3'b010, 3'b011, 3'b100, 3'b101};
    assign page   = 2'(seg - 3'd2);

    assign kon_wsel = is_konami & (seg inside {3'b011, 3'b100, 3'b101});
    assign scc_wsel = is_scc & in_rng & (bus.addr[12:11] == 2'b10);
    assign we       = commit & (kon_wsel | scc_wsel);

    konami_bank_file #(
        .SLOTS  (SLOTS),
        .BANK_W (BANK_W),
        .ID_W   (ID_W)
    ) u_bank_file (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_slot_i (slot),
        .wr_page_i (page),
        .wr_val_i  (BANK_W'(bus.data)),
        .we_i      (we),
        .rd_slot_i (slot),
        .rd_page_i (page),
        .rd_val_o  (rd_val),
        .rd_p2_o   (rd_p2)
    );

    // Plain Konami hardwires page 4000h to bank 0; its register is never used.
    assign bank_sel = (is_konami && page == 2'd0) ? '0 : rd_val;
    assign ram_addr = 27'({bank_sel, bus.addr[12:0]});

    assign scc_en = is_scc & scc_enabled(rd_p2);
    assign win    = scc_en & (bus.addr >= SCC_WIN_BASE) & (bus.addr <= SCC_WIN_END);
    assign mapped = in_rng & (ram_addr < bus.rom_size);

    assign scc_cs_d   = cs & (bus.rd | bus.wr) & win;
    assign ram_cs_d   = cs & bus.rd & mapped & ~win;
    assign out_addr_d = ram_cs_d ? ram_addr : '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q       <= 1'b0;
            out_addr_q <= '1;
            ram_cs_q   <= 1'b0;
            scc_cs_q   <= 1'b0;
        end else begin
            wr_q       <= bus.wr;
            out_addr_q <= out_addr_d;
            ram_cs_q   <= ram_cs_d;
            scc_cs_q   <= scc_cs_d;
        end
    end

    assign bus.out_addr = out_addr_q;
    assign bus.ram_cs   = ram_cs_q;
    assign bus.scc_cs   = scc_cs_q;

endmodule

// File: doc/mapper_konami_multi.md
# mapper_konami_multi

Parametrised Konami-family ROM mapper serving both plain Konami (fixed page at 4000h) and Konami-SCC cartridges across `SLOTS` independent cartridge instances. It sits between the CPU bus decode and the SDRAM/SCC arbiters in the slot subsystem. It translates 8 KB CPU pages into ROM byte addresses and commits bank-register writes exactly once per CPU write cycle. It also decodes the SCC register window, and registers all outputs.

## Interface
Parameters:
- `SLOTS`, 2, number of independent cartridge instances (bank-register sets)
- `BANK_W`, 8, bank register width; constraint `BANK_W + 13 <= 27`
- `ID_W`, `$clog2(SLOTS)` (min 1), width of `id`

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `typ`  in  mapper_typ_t  mapper type of the addressed slot
- `id`  in  ID_W  slot instance selecting the bank-register set
- `mreq`  in  1  CPU memory request
- `wr`  in  1  write strobe, may be held for multiple cycles
- `rd`  in  1  read strobe
- `addr`  in  16  CPU address
- `data`  in  8  CPU write data
- `rom_size`  in  27  ROM size in bytes for the addressed slot
- `out_addr`  out  27  ROM byte address; all ones when `ram_cs` is 0
- `ram_cs`  out  1  ROM read select
- `scc_cs`  out  1  SCC register window select

## Operation
- Active: `cs = mreq & (typ == MAPPER_KONAMI | typ == MAPPER_KONAMI_SCC) & (id < SLOTS)`. If `cs` is 0, the block performs no commit and produces no selects.
- Bank registers: four per slot, `bank[id][0..3]`, covering pages 4000h, 6000h, 8000h and A000h. Reset values are 0, 1, 2, 3 in every slot.
- Write commit: `wr_q` is `wr` delayed one clock (reset 0). A commit happens only when `cs & wr & ~wr_q`, so a held `wr` commits once. `data[BANK_W-1:0]` is stored, and upper bits are dropped when `BANK_W < 8`.
- Konami decode by `addr[15:13]`:
  - 011 → bank1; 100 → bank2; 101 → bank3.
  - 010 writes are ignored, and page 0 always reads as bank 0 (the register is unused).
- SCC decode, which applies only when `addr[12:11] == 2'b10`:
  - 5000–57FFh → bank0; 7000–77FFh → bank1; 9000–97FFh → bank2; B000–B7FFh → bank3.
  - Other writes in 4000–BFFFh are ignored.
- SCC enable: `scc_en = (bank[id][2][5:0] == 6'h3F)`, valid in SCC mode only.
- Translation: page index is `p = addr[15:13] - 2`. `ram_addr = {bank[id][p], addr[12:0]}`, zero-extended to 27 bits. In Konami mode page 0 uses a bank value of 0.
- `mapped = 4000h <= addr < C000h & ram_addr < rom_size`.
- SCC window: `win = SCC mode & scc_en & addr in 9800–9FFFh`.
- Next-state outputs:
  - `scc_cs_d = cs & (rd|wr) & win`
  - `ram_cs_d = cs & rd & mapped & ~win`
  - `out_addr_d = ram_cs_d ? ram_addr : '1`
- Writes never assert `ram_cs`, because the ROM is read-only.
- Out-of-range address (≥ `rom_size`): `ram_cs` is 0 and `out_addr` is all ones. There is no mirroring.

## Timing
- All three outputs are registered. Latency is one clock from the input sample to the output.
- Reset values: `out_addr` = 27'h7FFFFFF, `ram_cs` = 0, `scc_cs` = 0. All bank registers return to their reset values and `wr_q` = 0.
- Reset is asynchronous. It takes effect mid-access, and a commit in that cycle is lost.
- A commit in cycle N is visible to the translation sampled in cycle N+1. A translation in the same cycle uses the old value.
- Write to bank2 with 3Fh: `scc_en` rises for the cycle-N+1 sample. An SCC-window read in cycle N still goes to ROM.
- Back-to-back writes need `wr` to deassert for at least one clock between them, or the second write is not committed.
- `id` change while `wr` is held does not create a new commit. Edge detection is global, not per slot.

## Structure
- Shared `mapper_pkg` holds:
  - the `MAPPER_KONAMI_SCC` addition to `mapper_typ_t`
  - `KONAMI_BANK_RESET` = {0,1,2,3}
  - `SCC_ENABLE_VAL` = 6'h3F
  - `SCC_WIN_BASE` = 16'h9800 and `SCC_WIN_END` = 16'h9FFF
- Sub-module `konami_bank_file`: a `SLOTS`×4×`BANK_W` register array with async reset, a single write port (slot, page, value, we) and a combinational read port (slot, page).
- The top level contains the write-edge detector, the mode decoders and the output register stage.

## Test plan
- Reset then Konami read of 4000h, slot 0 → one cycle later `ram_cs`=1, `out_addr`=27'h0000000; a read of A123h gives `out_addr`=27'h0006123.
- Konami write of 05h to 8000h with `wr` held 4 cycles, then a read of 8010h → exactly one commit; `out_addr`=27'h000A010.
- Write 07h to 6000h on slot 1, then a slot-0 read of 6000h → slot 0 gives `out_addr`=27'h0002000; slot 1 gives 27'h000E000.
- SCC mode: write 3Fh to 9000h, then a read of 9800h → `scc_cs`=1, `ram_cs`=0; write 02h to 9000h, then a read of 9800h → `ram_cs`=1, `out_addr`=27'h0005800.
- `rom_size`=32 KB, bank3=04h, read of A000h → `ram_cs`=0, `out_addr` all ones.
- Assert `reset_n`=0 mid-write → outputs are immediately at reset values; bank registers read back 0,1,2,3.
